systolic_accelerator: RTL and testbench

Output-stationary GRID_SIZE×GRID_SIZE systolic matrix-multiply core; the bench instantiates it as `accelerator`. It streams pre-skewed operand buffers from the north (columns of B) and west (rows of A) edges through a mesh of multiply-accumulate PEs. Each PE accumulates one element of C = A·B. It has no data ports: buffers, enable and results are internal arrays, loaded and inspected hierarchically by the host or testbench.

---
 rtl/systolic_accelerator.sv | 101 ++++++++++
 tb/tb_systolic_accelerator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_accelerator.sv
// systolic_accelerator: output-stationary GRID_SIZE x GRID_SIZE matrix-multiply mesh.
// Operands stream in pre-skewed from north (columns of B) and west (rows of A)
// edge buffers; each PE accumulates one element of C = A*B in place.
// Buffers, ce and acc are loaded/inspected hierarchically by the host.
module systolic_accelerator #(
  parameter int unsigned NUM_SIZE   = 16,
  parameter int unsigned BUFFER_LEN = 8,
  parameter int unsigned GRID_SIZE  = 2
) (
  input logic clk,
  input logic rst
);

  // idx counts 0..BUFFER_LEN inclusive; the buffer address drops the top value
  localparam int unsigned IDX_W  = $clog2(BUFFER_LEN + 1);
  localparam int unsigned ADDR_W = (BUFFER_LEN > 1) ? $clog2(BUFFER_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BUFFER_LEN);

  // Externally visible state; declaration values give a clean power-up state
  // so the core works even if reset is never clocked.
  logic [NUM_SIZE-1:0] north_buffer [GRID_SIZE][BUFFER_LEN] = '{default: '0};
  logic [NUM_SIZE-1:0] west_buffer  [GRID_SIZE][BUFFER_LEN] = '{default: '0};
  logic                ce = 1'b0;
  logic [NUM_SIZE-1:0] acc   [GRID_SIZE][GRID_SIZE] = '{default: '0};
  logic [NUM_SIZE-1:0] a_reg [GRID_SIZE][GRID_SIZE] = '{default: '0};
  logic [NUM_SIZE-1:0] b_reg [GRID_SIZE][GRID_SIZE] = '{default: '0};
  logic [IDX_W-1:0]    idx = '0;

  logic                w_edge_valid;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [NUM_SIZE-1:0] w_west_in  [GRID_SIZE][GRID_SIZE];
  logic [NUM_SIZE-1:0] w_north_in [GRID_SIZE][GRID_SIZE];

  // Edge read address; once idx saturates the edges feed zeros
  always_comb begin
    w_edge_valid = (idx != IDX_MAX);
    w_rd_addr    = w_edge_valid ? idx[ADDR_W-1:0] : '0;
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < GRID_SIZE; gi++) begin : g_row
      for (gj = 0; gj < GRID_SIZE; gj++) begin : g_col
        if (gj == 0) begin : g_west_edge
          // Column 0 takes A straight from its west buffer
          always_comb begin
            w_west_in[gi][gj] = '0;
            if (w_edge_valid) w_west_in[gi][gj] = west_buffer[gi][w_rd_addr];
          end
        end else begin : g_west_mesh
          // Inner columns take A from the PE to the west
          always_comb begin
            w_west_in[gi][gj] = a_reg[gi][gj-1];
          end
        end

        if (gi == 0) begin : g_north_edge
          // Row 0 takes B straight from its north buffer
          always_comb begin
            w_north_in[gi][gj] = '0;
            if (w_edge_valid) w_north_in[gi][gj] = north_buffer[gj][w_rd_addr];
          end
        end else begin : g_north_mesh
          // Inner rows take B from the PE to the north
          always_comb begin
            w_north_in[gi][gj] = b_reg[gi-1][gj];
          end
        end
      end
    end
  endgenerate

  // Reset clears buffers and enable; otherwise the host owns them
  always_ff @(posedge clk) begin
    if (rst) begin
      ce           <= 1'b0;
      north_buffer <= '{default: '0};
      west_buffer  <= '{default: '0};
    end
  end

  // PE mesh: multiply-accumulate, forward operands, advance the shared read index
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '{default: '0};
      a_reg <= '{default: '0};
      b_reg <= '{default: '0};
      idx   <= '0;
    end else if (ce) begin
      for (int unsigned i = 0; i < GRID_SIZE; i++) begin
        for (int unsigned j = 0; j < GRID_SIZE; j++) begin
          acc[i][j]   <= acc[i][j] + w_west_in[i][j] * w_north_in[i][j];
          a_reg[i][j] <= w_west_in[i][j];
          b_reg[i][j] <= w_north_in[i][j];
        end
      end
      if (idx != IDX_MAX) idx <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_systolic_accelerator.sv
// Self-checking bench for systolic_accelerator: table vectors, hand-written
// pause/reset sequences and randomized products against a matrix model.
module tb_systolic_accelerator;

  localparam int unsigned N  = 16;
  localparam int unsigned BL = 8;
  localparam int unsigned G  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  systolic_accelerator #(
    .NUM_SIZE  (N),
    .BUFFER_LEN(BL),
    .GRID_SIZE (G)
  ) accelerator (
    .clk(clk),
    .rst(rst)
  );

  typedef struct {
    logic [15:0] a [2][4];
    logic [15:0] b [4][2];
    int unsigned k;
    int unsigned edges;
    logic [15:0] c [2][2];
    logic [3:0]  idx;
  } vec_t;

  vec_t tbl [5];

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Model operands: A is G x K, B is K x G
  logic [15:0] ma [2][8];
  logic [15:0] mb [8][2];
  int unsigned mk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] model_c(input int unsigned i, input int unsigned j);
    logic [31:0] s;
    s = 0;
    for (int unsigned k = 0; k < mk; k++) s = s + ma[i][k] * mb[k][j];
    return s[15:0];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 8; k++) begin
        ma[i][k] = '0;
        mb[k][i] = '0;
      end
    mk = 0;
  endtask

  task automatic model_from_vec(input int unsigned v);
    clear_model();
    mk = tbl[v].k;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = tbl[v].a[i][k];
        mb[k][i] = tbl[v].b[k][i];
      end
  endtask

  // Skewed load: row i of A and column j of B shifted by their index
  task automatic load_dut();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < int'(mk); k++) begin
        accelerator.west_buffer[i][k+i]  = ma[i][k];
        accelerator.north_buffer[i][k+i] = mb[k][i];
      end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run(input int unsigned n);
    if (n > 0) begin
      @(negedge clk);
      accelerator.ce = 1'b1;
      repeat (n) @(posedge clk);
      #1 accelerator.ce = 1'b0;
    end
  endtask

  task automatic hold(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string name);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        check($sformatf("%s acc[%0d][%0d]", name, i, j), accelerator.acc[i][j], model_c(i, j));
  endtask

  task automatic check_acc4(input string name, input logic [15:0] c00, input logic [15:0] c01,
                            input logic [15:0] c10, input logic [15:0] c11);
    check({name, " acc00"}, accelerator.acc[0][0], c00);
    check({name, " acc01"}, accelerator.acc[0][1], c01);
    check({name, " acc10"}, accelerator.acc[1][0], c10);
    check({name, " acc11"}, accelerator.acc[1][1], c11);
  endtask

  task automatic check_all_clear(input string name);
    logic [15:0] orv;
    orv = '0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 8; k++)
        orv = orv | accelerator.west_buffer[i][k] | accelerator.north_buffer[i][k];
    check({name, " buffers"}, orv, 16'h0);
    check_acc4(name, 16'd0, 16'd0, 16'd0, 16'd0);
    check({name, " idx"}, accelerator.idx, 4'd0);
    check({name, " ce"}, accelerator.ce, 1'b0);
  endtask

  initial begin
    int unsigned total, rem, chunk, exp_idx;

    tbl[0] = '{a: '{'{16'd3, 16'd1, 16'd0, 16'd0}, '{16'd4, 16'd1, 16'd0, 16'd0}},
               b: '{'{16'd2, 16'd1}, '{16'd7, 16'd8}, '{16'd0, 16'd0}, '{16'd0, 16'd0}},
               k: 2, edges: 4,
               c: '{'{16'd13, 16'd11}, '{16'd15, 16'd12}}, idx: 4'd4};
    tbl[1] = '{a: '{'{16'd3, 16'd1, 16'd0, 16'd0}, '{16'd4, 16'd1, 16'd0, 16'd0}},
               b: '{'{16'd2, 16'd1}, '{16'd7, 16'd8}, '{16'd0, 16'd0}, '{16'd0, 16'd0}},
               k: 2, edges: 10,
               c: '{'{16'd13, 16'd11}, '{16'd15, 16'd12}}, idx: 4'd8};
    tbl[2] = '{a: '{'{16'hFFFF, 16'd0, 16'd0, 16'd0}, '{16'd0, 16'd0, 16'd0, 16'd0}},
               b: '{'{16'd2, 16'd0}, '{16'd0, 16'd0}, '{16'd0, 16'd0}, '{16'd0, 16'd0}},
               k: 1, edges: 3,
               c: '{'{16'hFFFE, 16'd0}, '{16'd0, 16'd0}}, idx: 4'd3};
    tbl[3] = '{a: '{'{16'd1, 16'd2, 16'd3, 16'd4}, '{16'd5, 16'd6, 16'd7, 16'd8}},
               b: '{'{16'd1, 16'd0}, '{16'd0, 16'd1}, '{16'd1, 16'd1}, '{16'd2, 16'd3}},
               k: 4, edges: 6,
               c: '{'{16'd12, 16'd17}, '{16'd28, 16'd37}}, idx: 4'd6};
    tbl[4] = '{a: '{'{16'h8000, 16'd1, 16'd0, 16'd0}, '{16'd0, 16'd0, 16'd0, 16'd0}},
               b: '{'{16'd2, 16'd0}, '{16'd5, 16'd0}, '{16'd0, 16'd0}, '{16'd0, 16'd0}},
               k: 2, edges: 4,
               c: '{'{16'd5, 16'd0}, '{16'd0, 16'd0}}, idx: 4'd4};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all_clear("reset");

    // Table vectors: expected results are hand-derived constants
    for (int v = 0; v < 5; v++) begin
      apply_reset();
      model_from_vec(v);
      load_dut();
      run(tbl[v].edges);
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          check($sformatf("vec%0d acc[%0d][%0d]", v, i, j), accelerator.acc[i][j], tbl[v].c[i][j]);
      check($sformatf("vec%0d idx", v), accelerator.idx, tbl[v].idx);
    end

    // ce held low: nothing moves
    apply_reset();
    model_from_vec(0);
    load_dut();
    hold(20);
    check_acc4("ce_low", 16'd0, 16'd0, 16'd0, 16'd0);
    check("ce_low idx", accelerator.idx, 4'd0);

    // Pause mid-stream: partial sums freeze, then resume to the full result
    apply_reset();
    model_from_vec(0);
    load_dut();
    run(2);
    check_acc4("pause_partial", 16'd13, 16'd3, 16'd8, 16'd0);
    hold(5);
    check_acc4("pause_frozen", 16'd13, 16'd3, 16'd8, 16'd0);
    check("pause_frozen idx", accelerator.idx, 4'd2);
    run(4);
    check_acc4("pause_resumed", 16'd13, 16'd11, 16'd15, 16'd12);
    check("pause_resumed idx", accelerator.idx, 4'd6);

    // Reset mid-stream aborts and clears everything; a rerun recovers
    apply_reset();
    model_from_vec(0);
    load_dut();
    run(2);
    @(negedge clk);
    accelerator.ce = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_all_clear("midreset");
    load_dut();
    run(4);
    check_acc4("rerun", 16'd13, 16'd11, 16'd15, 16'd12);

    // Randomized products with random ce gaps
    for (int t = 0; t < 25; t++) begin
      clear_model();
      mk = $urandom_range(1, 7);
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < int'(mk); k++) begin
          ma[i][k] = 16'($urandom);
          mb[k][i] = 16'($urandom);
        end
      apply_reset();
      load_dut();
      total = mk + 2 + $urandom_range(0, 3);
      rem = total;
      while (rem > 0) begin
        chunk = $urandom_range(1, rem);
        run(chunk);
        hold($urandom_range(0, 3));
        rem = rem - chunk;
      end
      check_model($sformatf("rand%0d", t));
      exp_idx = (total > BL) ? BL : total;
      check($sformatf("rand%0d idx", t), accelerator.idx, exp_idx);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
